// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial pattern detector with saturating match counter
module seq_detect_prog #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8,
    parameter int LENW   = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [MAXLEN-1:0] pat_in,
    input  logic [LENW-1:0]   len_in,
    input  logic              ovl_in,
    input  logic              en,
    input  logic              x,
    input  logic              cnt_clr,
    output logic              z,
    output logic [CNTW-1:0]   count,
    output logic              armed,
    output logic              cfg_err
);

    typedef enum logic {
        UNCONF = 1'b0,
        ARMED  = 1'b1
    } state_t;

    localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

    state_t            state_q;
    logic [MAXLEN-1:0] pat_q;
    logic [LENW-1:0]   len_q;
    logic              ovl_q;
    logic [MAXLEN-1:0] hist_q;
    logic [LENW-1:0]   fill_q;
    logic              z_q;
    logic [CNTW-1:0]   count_q;
    logic              cfg_err_q;

    logic [MAXLEN-1:0] hist_d;
    logic [LENW-1:0]   fill_d;
    logic [MAXLEN-1:0] mask;
    logic              load_ok;
    logic              sample;
    logic              match;

    // Candidate history/fill as if this cycle's bit is taken; the match is judged on them.
    always_comb begin
        hist_d  = {hist_q[MAXLEN-2:0], x};
        fill_d  = (fill_q == MAXLEN_L) ? fill_q : fill_q + 1'b1;
        mask    = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (LENW'(i) < len_q);
        end
        load_ok = (len_in != '0) && (len_in <= MAXLEN_L);
        sample  = en && !load && (state_q == ARMED);
        match   = sample && (fill_d >= len_q) && (((hist_d ^ pat_q) & mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UNCONF;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            z_q       <= 1'b0;
            count_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            z_q       <= 1'b0;
            cfg_err_q <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    pat_q   <= pat_in;
                    len_q   <= len_in;
                    ovl_q   <= ovl_in;
                    hist_q  <= '0;
                    fill_q  <= '0;
                    state_q <= ARMED;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end else if (sample) begin
                z_q <= match;
                // Non-overlap mode discards every bit of a completed pattern.
                if (match && !ovl_q) begin
                    hist_q <= '0;
                    fill_q <= '0;
                end else begin
                    hist_q <= hist_d;
                    fill_q <= fill_d;
                end
            end
            if (cnt_clr) begin
                count_q <= '0;
            end else if (match && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign z       = z_q;
    assign count   = count_q;
    assign armed   = (state_q == ARMED);
    assign cfg_err = cfg_err_q;

endmodule
